// File: rtl/image_process.sv
`timescale 1ns/1ps
// image_process: RGB565 -> grayscale -> 3x3 Sobel -> binary RGB565 edge map.
// Five-stage free-running pipeline; a valid bit and the frame markers travel
// alongside every pixel, so gaps on the input reappear unchanged on the output.
module image_process #(
  parameter int H_ACTIVE  = 1280,
  parameter int V_ACTIVE  = 720,
  parameter int THRESHOLD = 100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        din_sop,
  input  logic        din_eop,
  input  logic        din_vld,
  input  logic [15:0] din,
  output logic        dout_sop,
  output logic        dout_eop,
  output logic        dout_vld,
  output logic [15:0] dout
);

  localparam int COL_W = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int ROW_W = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;

  // ---------------------------------------------------------------
  // Position tagging
  // ---------------------------------------------------------------
  logic [COL_W-1:0] col_reg;
  logic [ROW_W-1:0] row_reg;
  logic [COL_W-1:0] col_tag;
  logic [ROW_W-1:0] row_tag;

  // A valid sop forces the current pixel to (0,0) so a stray frame resyncs
  always_comb begin
    col_tag = din_sop ? '0 : col_reg;
    row_tag = din_sop ? '0 : row_reg;
  end

  // Raster position of the next pixel, advanced only on valid input
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_reg <= '0;
      row_reg <= '0;
    end else if (din_vld) begin
      if (col_tag == COL_W'(H_ACTIVE - 1)) begin
        col_reg <= '0;
        row_reg <= (row_tag == ROW_W'(V_ACTIVE - 1)) ? '0 : row_tag + ROW_W'(1);
      end else begin
        col_reg <= col_tag + COL_W'(1);
        row_reg <= row_tag;
      end
    end
  end

  // ---------------------------------------------------------------
  // Sideband pipeline: index 0 = S1 ... index 4 = S5
  // ---------------------------------------------------------------
  logic [4:0] vld_pipe_reg;
  logic [4:0] sop_pipe_reg;
  logic [4:0] eop_pipe_reg;
  logic [3:0] border_pipe_reg;

  // Valid, frame markers and the border flag ride along with each pixel
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe_reg    <= '0;
      sop_pipe_reg    <= '0;
      eop_pipe_reg    <= '0;
      border_pipe_reg <= '0;
    end else begin
      vld_pipe_reg    <= {vld_pipe_reg[3:0], din_vld};
      sop_pipe_reg    <= {sop_pipe_reg[3:0], din_sop & din_vld};
      eop_pipe_reg    <= {eop_pipe_reg[3:0], din_eop & din_vld};
      border_pipe_reg <= {border_pipe_reg[2:0],
                          (row_tag < ROW_W'(2)) || (col_tag < COL_W'(2))};
    end
  end

  // ---------------------------------------------------------------
  // S1 / S2: grayscale
  // ---------------------------------------------------------------
  logic [7:0]       r8, g8, b8;
  logic [15:0]      prod_r_reg, prod_g_reg, prod_b_reg;
  logic [7:0]       gray_reg;
  logic [COL_W-1:0] col1_reg, col2_reg;

  assign r8 = {din[15:11], din[15:13]};
  assign g8 = {din[10:5],  din[10:9]};
  assign b8 = {din[4:0],   din[4:2]};

  // S1 weighted channels (weights sum to 256, so white maps to 255) and S2 sum
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_r_reg <= '0;
      prod_g_reg <= '0;
      prod_b_reg <= '0;
      col1_reg   <= '0;
      gray_reg   <= '0;
      col2_reg   <= '0;
    end else begin
      prod_r_reg <= 16'(r8) * 16'd77;
      prod_g_reg <= 16'(g8) * 16'd150;
      prod_b_reg <= 16'(b8) * 16'd29;
      col1_reg   <= col_tag;
      gray_reg   <= 8'((prod_r_reg + prod_g_reg + prod_b_reg) >> 8);
      col2_reg   <= col1_reg;
    end
  end

  // ---------------------------------------------------------------
  // Line buffers: read issued one stage early so the registered read
  // data lines up with the gray value when the window shifts in S3.
  // ---------------------------------------------------------------
  logic [7:0] lb1_mem [0:H_ACTIVE-1];
  logic [7:0] lb2_mem [0:H_ACTIVE-1];
  logic [7:0] lb1_q_reg, lb2_q_reg;

  // Registered read of rows r-1/r-2; write back rotates the rows down by one
  always_ff @(posedge clk) begin
    lb1_q_reg <= lb1_mem[col1_reg];
    lb2_q_reg <= lb2_mem[col1_reg];
    if (vld_pipe_reg[1]) begin
      lb1_mem[col2_reg] <= gray_reg;
      lb2_mem[col2_reg] <= lb1_q_reg;
    end
  end

  // ---------------------------------------------------------------
  // S3: 3x3 window, row 0 = oldest row, element 0 = oldest column
  // ---------------------------------------------------------------
  logic [7:0] col_in [0:2];
  assign col_in[0] = lb2_q_reg;
  assign col_in[1] = lb1_q_reg;
  assign col_in[2] = gray_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_win_row
      logic [7:0] pix_reg [0:2];
      // Shift this window row left on each valid pixel, newest on the right
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          pix_reg[0] <= '0;
          pix_reg[1] <= '0;
          pix_reg[2] <= '0;
        end else if (vld_pipe_reg[1]) begin
          pix_reg[0] <= pix_reg[1];
          pix_reg[1] <= pix_reg[2];
          pix_reg[2] <= col_in[gi];
        end
      end
    end
  endgenerate

  // ---------------------------------------------------------------
  // S4: gradients
  // ---------------------------------------------------------------
  logic [10:0] p11, p12, p13, p21, p23, p31, p32, p33;
  assign p11 = {3'b000, g_win_row[0].pix_reg[0]};
  assign p12 = {3'b000, g_win_row[0].pix_reg[1]};
  assign p13 = {3'b000, g_win_row[0].pix_reg[2]};
  assign p21 = {3'b000, g_win_row[1].pix_reg[0]};
  assign p23 = {3'b000, g_win_row[1].pix_reg[2]};
  assign p31 = {3'b000, g_win_row[2].pix_reg[0]};
  assign p32 = {3'b000, g_win_row[2].pix_reg[1]};
  assign p33 = {3'b000, g_win_row[2].pix_reg[2]};

  logic signed [10:0] gx_reg, gy_reg;

  // Sobel gradients; 11-bit two's complement covers +/-1020
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gx_reg <= '0;
      gy_reg <= '0;
    end else begin
      gx_reg <= (p13 + (p23 << 1) + p33) - (p11 + (p21 << 1) + p31);
      gy_reg <= (p31 + (p32 << 1) + p33) - (p11 + (p12 << 1) + p13);
    end
  end

  // ---------------------------------------------------------------
  // S5: magnitude, threshold, border suppression
  // ---------------------------------------------------------------
  logic [10:0] abs_gx, abs_gy, mag;
  logic [15:0] dout_reg;

  assign abs_gx = gx_reg[10] ? 11'(-gx_reg) : gx_reg;
  assign abs_gy = gy_reg[10] ? 11'(-gy_reg) : gy_reg;
  assign mag    = abs_gx + abs_gy;

  // Binary edge pixel; invalid slots and border pixels are forced black
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_reg <= '0;
    end else begin
      dout_reg <= (vld_pipe_reg[3] && !border_pipe_reg[3] && (mag >= 11'(THRESHOLD)))
                  ? 16'hFFFF : 16'h0000;
    end
  end

  assign dout     = dout_reg;
  assign dout_vld = vld_pipe_reg[4];
  assign dout_sop = sop_pipe_reg[4];
  assign dout_eop = eop_pipe_reg[4];

endmodule

// File: tb/tb_image_process.sv
`timescale 1ns/1ps
// Bench for image_process on a reduced 16x8 frame. A frame-level reference
// computes each expected edge pixel from the stored gray image when the pixel
// is driven; the monitor pops and compares when dout_vld appears.
module tb_image_process;

  localparam int H   = 16;
  localparam int V   = 8;
  localparam int THR = 100;

  logic        clk;
  logic        rst_n;
  logic        din_sop, din_eop, din_vld;
  logic [15:0] din;
  logic        dout_sop, dout_eop, dout_vld;
  logic [15:0] dout;

  image_process #(.H_ACTIVE(H), .V_ACTIVE(V), .THRESHOLD(THR)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .din_sop  (din_sop),
    .din_eop  (din_eop),
    .din_vld  (din_vld),
    .din      (din),
    .dout_sop (dout_sop),
    .dout_eop (dout_eop),
    .dout_vld (dout_vld),
    .dout     (dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] d;
    bit          sop;
    bit          eop;
    int          cyc;
    int          white;
  } exp_t;

  exp_t exp_q[$];
  int   gimg [V][H];
  int   cyc;
  int   n_checks;
  int   n_errors;
  int   n_pushed;
  int   n_out;
  int   white_cnt;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int gray_of(input logic [15:0] p);
    int r8, g8, b8;
    r8 = int'({p[15:11], p[15:13]});
    g8 = int'({p[10:5],  p[10:9]});
    b8 = int'({p[4:0],   p[4:2]});
    return (77 * r8 + 150 * g8 + 29 * b8) / 256;
  endfunction

  // Window rows r-2..r, cols c-2..c of the current frame's gray image
  function automatic logic [15:0] ref_pix(input int r, input int c);
    int gx, gy, mag;
    if (r < 2 || c < 2) return 16'h0000;
    gx = (gimg[r-2][c] + 2 * gimg[r-1][c] + gimg[r][c])
       - (gimg[r-2][c-2] + 2 * gimg[r-1][c-2] + gimg[r][c-2]);
    gy = (gimg[r][c-2] + 2 * gimg[r][c-1] + gimg[r][c])
       - (gimg[r-2][c-2] + 2 * gimg[r-2][c-1] + gimg[r-2][c]);
    mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
    return (mag >= THR) ? 16'hFFFF : 16'h0000;
  endfunction

  // mode: 0 white, 1 vertical edge, 2 horizontal edge,
  //       3 step to gray 25, 4 step to gray 24, 5 random
  function automatic logic [15:0] make_pix(input int mode, input int r, input int c);
    case (mode)
      0:       return 16'hFFFF;
      1:       return (c < H / 2) ? 16'h0000 : 16'hFFFF;
      2:       return (r < V / 2) ? 16'h0000 : 16'hFFFF;
      3:       return (c < H / 2) ? 16'h0000 : {5'd3, 6'd6, 5'd4};
      4:       return (c < H / 2) ? 16'h0000 : {5'd3, 6'd6, 5'd3};
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic idle_cycle();
    @(posedge clk); #1;
    din_vld = 1'b0;
    din_sop = 1'b0;
    din_eop = 1'b0;
    din     = 16'($urandom);
  endtask

  task automatic send_frame(input int mode, input int line_gap, input bit rnd_gap,
                            input int stop_at, input bit rst_at_stop, input int exp_white);
    logic [15:0] p;
    exp_t        e;
    for (int r = 0; r < V; r++) begin
      for (int c = 0; c < H; c++) begin
        if (r * H + c == stop_at) begin
          if (rst_at_stop) begin
            @(posedge clk); #1;
            din_vld  = 1'b0;
            din_sop  = 1'b0;
            din_eop  = 1'b0;
            rst_n    = 1'b0;
            n_pushed = n_pushed - exp_q.size();
            exp_q.delete();
            @(negedge clk);
            check_eq("rst_mid_vld", int'(dout_vld), 0);
            check_eq("rst_mid_dout", int'(dout), 0);
            @(posedge clk); #1;
            rst_n = 1'b1;
          end else begin
            idle_cycle();
          end
          $display("frame mode=%0d aborted at pixel %0d reset=%0b", mode, stop_at, rst_at_stop);
          return;
        end
        p = make_pix(mode, r, c);
        gimg[r][c] = gray_of(p);
        @(posedge clk); #1;
        din_vld = 1'b1;
        din     = p;
        din_sop = (r == 0 && c == 0);
        din_eop = (r == V - 1 && c == H - 1);
        e.d     = ref_pix(r, c);
        e.sop   = din_sop;
        e.eop   = din_eop;
        e.cyc   = cyc + 5;
        e.white = exp_white;
        exp_q.push_back(e);
        n_pushed++;
        if (rnd_gap && $urandom_range(0, 3) == 0) idle_cycle();
      end
      repeat (line_gap) idle_cycle();
    end
    $display("frame mode=%0d sent", mode);
  endtask

  // Scoreboard: one comparison set per output pixel
  always @(negedge clk) begin
    exp_t e;
    if (dout_vld) begin
      n_out++;
      if (exp_q.size() == 0) begin
        check_eq("unexpected_vld", 1, 0);
      end else begin
        e = exp_q.pop_front();
        $display("out pix d=%h sop=%0b eop=%0b t=%0d", dout, dout_sop, dout_eop, cyc);
        check_eq("dout", int'(dout), int'(e.d));
        check_eq("dout_sop", int'(dout_sop), int'(e.sop));
        check_eq("dout_eop", int'(dout_eop), int'(e.eop));
        check_eq("latency", cyc, e.cyc);
        if (dout_sop) white_cnt = 0;
        if (dout == 16'hFFFF) white_cnt++;
        if (e.eop && e.white >= 0) check_eq("white_count", white_cnt, e.white);
      end
    end
  end

  initial begin
    int n;
    rst_n   = 1'b0;
    din_vld = 1'b0;
    din_sop = 1'b0;
    din_eop = 1'b0;
    din     = 16'h0000;

    repeat (2) begin
      @(negedge clk);
      check_eq("rst_vld", int'(dout_vld), 0);
      check_eq("rst_sop", int'(dout_sop), 0);
      check_eq("rst_eop", int'(dout_eop), 0);
      check_eq("rst_dout", int'(dout), 0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check_eq("idle_vld", int'(dout_vld), 0);
      check_eq("idle_dout", int'(dout), 0);
    end

    send_frame(0, 3, 1'b0, -1, 1'b0, 0);
    send_frame(1, 2, 1'b1, -1, 1'b0, (V - 2) * 2);
    send_frame(2, 0, 1'b0, -1, 1'b0, 2 * (H - 2));
    send_frame(3, 1, 1'b0, -1, 1'b0, (V - 2) * 2);
    send_frame(4, 1, 1'b0, -1, 1'b0, 0);
    send_frame(5, 2, 1'b1, -1, 1'b0, -1);
    send_frame(5, 0, 1'b1, -1, 1'b0, -1);
    send_frame(5, 1, 1'b1, 37, 1'b0, -1);
    send_frame(5, 1, 1'b1, -1, 1'b0, -1);
    send_frame(5, 1, 1'b1, 70, 1'b1, -1);
    send_frame(5, 2, 1'b1, -1, 1'b0, -1);
    idle_cycle();

    n = 0;
    while (exp_q.size() > 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    repeat (3) @(posedge clk);
    check_eq("drain_empty", exp_q.size(), 0);
    check_eq("out_count", n_out, n_pushed);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/image_process.md
Name: image_process

Overview:
- Streaming per-pixel image processing stage between the CMOS capture path and the SDRAM/VGA frame path.
- Accepts RGB565 pixels with sop/eop/vld framing.
- Converts each pixel to 8-bit grayscale, then runs a 3x3 Sobel edge detector using two line buffers.
- Emits a binary edge image as RGB565 (white 16'hFFFF / black 16'h0000) with identical framing, one output pixel per input pixel.

Parameters:
- H_ACTIVE, 1280, active pixels per line (`H_AP).
- V_ACTIVE, 720, active lines per frame (`V_AP).
- THRESHOLD, 100, edge threshold applied to |Gx|+|Gy| (11-bit compare).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- din_sop  input  1  first pixel of frame; qualified by din_vld.
- din_eop  input  1  last pixel of frame; qualified by din_vld.
- din_vld  input  1  input pixel valid.
- din  input  16  RGB565 pixel {R[4:0],G[5:0],B[4:0]}.
- dout_sop  output  1  start of frame, aligned with dout_vld.
- dout_eop  output  1  end of frame, aligned with dout_vld.
- dout_vld  output  1  output pixel valid.
- dout  output  16  RGB565 edge pixel.

Behaviour:
- Reset: all outputs 0; counters, pipeline valids and window registers cleared. Line buffer contents are don't-care.
- Reset mid-frame: counters restart at (0,0); in-flight pixels are discarded.
- The pipeline is free-running; a valid bit travels with each pixel through every stage.
  - Fixed latency: exactly 5 clocks from din_vld to dout_vld.
  - sop/eop are delayed identically.
  - Gaps in din_vld produce matching gaps in dout_vld and never stall pixels already in flight.
- Position counters col (0..H_ACTIVE-1) and row (0..V_ACTIVE-1) tag each input pixel.
  - They advance only on din_vld.
  - col wraps to 0 and increments row; row wraps to 0 after V_ACTIVE-1.
  - din_sop&din_vld forces the current pixel to (0,0) to resync.
- S1 (grayscale products):
  - Expand R8={R,R[4:2]}, G8={G,G[5:4]}, B8={B,B[4:2]}.
  - Register 77*R8, 150*G8, 29*B8.
- S2 (grayscale sum): gray = (sum)>>8, 8 bits. 0xFFFF gives 255; 0x0000 gives 0.
- S3 (window update), on valid only:
  - Read line buffers LB1 (row-1) and LB2 (row-2) at address col.
  - Write LB2[col]<=LB1[col] and LB1[col]<=gray.
  - Shift 3x3 window left; new right column = {LB2 out, LB1 out, gray}.
  - Window element pRC: R=1 is oldest row, C=1 is oldest column.
- S4 (gradients), signed 11-bit:
  - Gx=(p13+2p23+p33)-(p11+2p21+p31).
  - Gy=(p31+2p32+p33)-(p11+2p12+p13).
- S5 (output):
  - mag=|Gx|+|Gy|.
  - dout=16'hFFFF if mag>=THRESHOLD, else 16'h0000.
  - Border rule: pixels tagged row<2 or col<2 output 16'h0000 regardless of mag.
- The output pixel at tag (r,c) uses the window of rows r-2..r and cols c-2..c; no centering shift.
- Output pixel count per frame equals input count (H_ACTIVE*V_ACTIVE).
- Back-to-back frames: no dead cycles are required between eop and the next sop.

Test Plan:
- Reset then idle: rst_n low 2 cycles -> dout_vld/sop/eop=0 and dout=0 throughout; nothing emitted until din_vld.
- Uniform frame: 1280x720 pixels of 0xFFFF, 10-cycle vld gaps per line -> every dout=0x0000. dout_sop appears 5 clocks after din_sop, dout_eop 5 clocks after din_eop (row 719, col 1279), exactly 921600 dout_vld pulses.
- Vertical edge: cols 0..639=0x0000, cols 640..1279=0xFFFF -> rows>=2: dout=0xFFFF at cols 640 and 641 (Gx=1020), 0x0000 elsewhere; rows 0-1 all 0x0000.
- Horizontal edge: rows 0..359 black, 360..719 white -> dout=0xFFFF at rows 360 and 361 for cols>=2, 0x0000 elsewhere.
- Threshold boundary: step of gray 0 to gray 25 (|Gx|=100) -> 0xFFFF; gray 24 (|Gx|=96) -> 0x0000.
- Random 2-frame stream with inter-line gaps plus reset asserted mid-frame -> output matches a bit-exact reference model; after reset, the next din_sop resyncs and the frame output is correct.
